// File: rtl/dmem_arb_pkg.sv
// Shared types, constants and the address legality check for the
// data-memory arbiter.
package dmem_arb_pkg;

    // Bytes per data-memory word; burst addresses advance by this amount.
    localparam int WORD_BYTES = 4;

    // IDLE arbitrates every cycle; BURST means the debug port owns memory.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // An access is legal when its word index is inside the memory and, for
    // anything other than a byte store, the byte address is word aligned.
    function automatic logic addr_ok(input logic [31:0] addr,
                                     input logic        sb,
                                     input logic [31:0] depth);
        logic in_range;
        logic aligned;
        in_range = ({2'b00, addr[31:2]} < depth);
        aligned  = sb || (addr[1:0] == 2'b00);
        return in_range && aligned;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// CPU MEM-stage and debug/loader signal bundle seen by the arbiter.
// slave = arbiter side, master = the requesters (pipeline and debug port).
interface dmem_arbiter_if #(
    parameter int BURST_W = 3
);
    // CPU MEM stage
    logic               cpu_req;
    logic               cpu_we;
    logic               cpu_sb;
    logic [31:0]        cpu_addr;
    logic [31:0]        cpu_wdata;
    logic [31:0]        cpu_rdata;
    logic               cpu_stall;

    // Debug / loader burst port
    logic               dbg_valid;
    logic               dbg_we;
    logic [31:0]        dbg_addr;
    logic [BURST_W-1:0] dbg_len;
    logic [31:0]        dbg_wdata;
    logic               dbg_ready;
    logic [31:0]        dbg_rdata;
    logic               dbg_rvalid;
    logic               dbg_done;

    modport slave (
        input  cpu_req, cpu_we, cpu_sb, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dbg_valid, dbg_we, dbg_addr, dbg_len, dbg_wdata,
        output dbg_ready, dbg_rdata, dbg_rvalid, dbg_done
    );

    modport master (
        output cpu_req, cpu_we, cpu_sb, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dbg_valid, dbg_we, dbg_addr, dbg_len, dbg_wdata,
        input  dbg_ready, dbg_rdata, dbg_rvalid, dbg_done
    );

endinterface

// File: rtl/dmem_addr_check.sv
// Combinational range/alignment check for one access path.
module dmem_addr_check
    import dmem_arb_pkg::*;
#(
    parameter int DEPTH = 10
) (
    input  logic [31:0] addr,
    input  logic        sb,
    output logic        ok
);

    assign ok = addr_ok(addr, sb, 32'(DEPTH));

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage and a
// debug/loader burst port. CPU has fixed priority; a pending debug command
// is forced through after MAX_WAIT denied cycles. Illegal addresses never
// write, read back as zero and raise a sticky error flag.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DEPTH    = 10,
    parameter int MAX_WAIT = 4,
    parameter int BURST_W  = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    dmem_arbiter_if.slave bus,
    output logic        mem_we,
    output logic        mem_sb,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd,
    output logic        addr_err
);

    localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
    localparam logic [31:0]       STRIDE   = 32'(WORD_BYTES);

    arb_state_t         state_reg,      state_next;
    logic [WAIT_W-1:0]  wait_cnt_reg,   wait_cnt_next;
    logic [BURST_W-1:0] remain_reg,     remain_next;
    logic [31:0]        cur_addr_reg,   cur_addr_next;
    logic               bwe_reg,        bwe_next;
    logic [31:0]        dbg_rdata_reg,  dbg_rdata_next;
    logic               dbg_rvalid_reg, dbg_rvalid_next;
    logic               dbg_done_reg,   dbg_done_next;
    logic               addr_err_reg,   addr_err_next;

    logic        in_idle;
    logic        dbg_force;
    logic        dbg_grant;
    logic        beat;
    logic        cpu_grant;
    logic        last_beat;
    logic        beat_we;
    logic [31:0] beat_addr;
    logic        cpu_ok;
    logic        dbg_ok;

    // Decide who owns memory this cycle. Everything is held off while reset
    // is asserted so that an abandoned burst cannot produce a stray beat.
    always_comb begin
        in_idle   = (state_reg == IDLE);
        dbg_force = (wait_cnt_reg == WAIT_MAX);
        dbg_grant = reset_n && in_idle && bus.dbg_valid &&
                    (!bus.cpu_req || dbg_force);
        beat      = dbg_grant || (reset_n && !in_idle && bus.dbg_valid);
        cpu_grant = reset_n && in_idle && bus.cpu_req && !dbg_grant;
        // First beat takes the command fields live; later beats use latched ones.
        beat_addr = in_idle ? bus.dbg_addr : cur_addr_reg;
        beat_we   = in_idle ? bus.dbg_we   : bwe_reg;
        last_beat = in_idle ? (bus.dbg_len == '0)
                            : (remain_reg == BURST_W'(1));
    end

    dmem_addr_check #(.DEPTH(DEPTH)) u_cpu_chk (
        .addr (bus.cpu_addr),
        .sb   (bus.cpu_sb),
        .ok   (cpu_ok)
    );

    // Debug beats are always full words, so byte alignment is never excused.
    dmem_addr_check #(.DEPTH(DEPTH)) u_dbg_chk (
        .addr (beat_addr),
        .sb   (1'b0),
        .ok   (dbg_ok)
    );

    // Route the winner onto the memory bus; idle cycles drive zeros.
    always_comb begin
        mem_we = 1'b0;
        mem_sb = 1'b0;
        mem_a  = '0;
        mem_wd = '0;
        if (beat) begin
            mem_a  = beat_addr;
            mem_wd = bus.dbg_wdata;
            mem_we = beat_we && dbg_ok;
        end else if (cpu_grant) begin
            mem_a  = bus.cpu_addr;
            mem_wd = bus.cpu_wdata;
            mem_we = bus.cpu_we && cpu_ok;
            mem_sb = bus.cpu_sb;
        end
    end

    assign bus.dbg_ready  = beat;
    assign bus.cpu_stall  = reset_n && bus.cpu_req && !cpu_grant;
    assign bus.cpu_rdata  = (cpu_grant && cpu_ok) ? mem_rd : '0;
    assign bus.dbg_rdata  = dbg_rdata_reg;
    assign bus.dbg_rvalid = dbg_rvalid_reg;
    assign bus.dbg_done   = dbg_done_reg;
    assign addr_err       = addr_err_reg;

    // Next-state: burst bookkeeping, starvation counter and response registers.
    always_comb begin
        state_next      = state_reg;
        remain_next     = remain_reg;
        cur_addr_next   = cur_addr_reg;
        bwe_next        = bwe_reg;
        dbg_rdata_next  = dbg_rdata_reg;
        dbg_rvalid_next = beat && !beat_we;
        dbg_done_next   = beat && last_beat;
        addr_err_next   = addr_err_reg || (beat && !dbg_ok) ||
                          (cpu_grant && !cpu_ok);

        // Count only cycles where a debug command is actually being refused.
        if (!bus.dbg_valid || dbg_grant || !in_idle) begin
            wait_cnt_next = '0;
        end else if (wait_cnt_reg != WAIT_MAX) begin
            wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
        end else begin
            wait_cnt_next = wait_cnt_reg;
        end

        if (beat) begin
            cur_addr_next = beat_addr + STRIDE;
            if (!beat_we) begin
                dbg_rdata_next = dbg_ok ? mem_rd : '0;
            end
            if (in_idle) begin
                bwe_next    = bus.dbg_we;
                remain_next = bus.dbg_len;
                state_next  = (bus.dbg_len != '0) ? BURST : IDLE;
            end else begin
                remain_next = remain_reg - BURST_W'(1);
                if (last_beat) begin
                    state_next = IDLE;
                end
            end
        end
    end

    // State registers; asynchronous reset abandons any burst in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            wait_cnt_reg   <= '0;
            remain_reg     <= '0;
            cur_addr_reg   <= '0;
            bwe_reg        <= 1'b0;
            dbg_rdata_reg  <= '0;
            dbg_rvalid_reg <= 1'b0;
            dbg_done_reg   <= 1'b0;
            addr_err_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            wait_cnt_reg   <= wait_cnt_next;
            remain_reg     <= remain_next;
            cur_addr_reg   <= cur_addr_next;
            bwe_reg        <= bwe_next;
            dbg_rdata_reg  <= dbg_rdata_next;
            dbg_rvalid_reg <= dbg_rvalid_next;
            dbg_done_reg   <= dbg_done_next;
            addr_err_reg   <= addr_err_next;
        end
    end

endmodule
